morra_tabellone: RTL and testbench
==================================

# morra_tabellone

Scoreboard stage directly downstream of the MorraCinese FSMD. It consumes the per-round result (MANCHE) and match result (PARTITA) every clock, and keeps per-match and per-session tallies. On each match end it emits one report record over a valid/ready handshake to the display/logging stage. It feeds nothing back to the FSMD.

## Interface
- CONT_W, 4, width of per-match counters (saturating)
- SESS_W, 8, width of session counters (saturating)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high; dominates every other input
- INIZIA  in  1  same start signal fed to the FSMD; starts a new match
- MANCHE  in  2  round result from FSMD: 00 none/invalid, 01 player 1, 10 player 2, 11 draw
- PARTITA  in  2  match result from FSMD: 00 ongoing, 01 player 1, 10 player 2, 11 draw
- STATO  out  2  00 IDLE, 01 GIOCO, 10 FINE (11 unused)
- VITTORIE_1, VITTORIE_2, PAREGGI  out  CONT_W  rounds won by P1 / won by P2 / drawn in current match
- MANCHE_GIOCATE  out  CONT_W  valid rounds (MANCHE≠00) in current match
- PARTITE_1, PARTITE_2, PARTITE_PARI  out  SESS_W  matches won by P1 / won by P2 / drawn since reset
- REPORT_VALID  out  1  report record available
- REPORT_READY  in  1  consumer accepts record
- REPORT_DATA  out  2+3*CONT_W  {winner[1:0], VITTORIE_1, VITTORIE_2, MANCHE_GIOCATE} captured at match end
- PERSO  out  1  sticky: a report was dropped

## Operation
- The FSM has three states: IDLE, GIOCO and FINE.
  - IDLE/FINE: MANCHE and PARTITA are ignored unless INIZIA=1.
  - INIZIA=1 in any state: clear the four match counters, then apply this cycle's MANCHE as the first round of the new match. Next state is GIOCO, or FINE if PARTITA≠00 in the same cycle.
  - GIOCO, PARTITA=00: apply MANCHE and stay in GIOCO.
  - GIOCO, PARTITA≠00: apply MANCHE (the final round counts), then go to FINE.
- Applying MANCHE:
  - 01: VITTORIE_1+1.
  - 10: VITTORIE_2+1.
  - 11: PAREGGI+1.
  - Any of 01/10/11 also increments MANCHE_GIOCATE.
  - 00: no change.
- All counters saturate at all-ones and never wrap.
- Match end (entry into FINE):
  - Increment PARTITE_1, PARTITE_2 or PARTITE_PARI according to PARTITA.
  - Form a report from the post-update counter values, with winner=PARTITA.
- Report register (single entry):
  - Load the new report when REPORT_VALID=0, or when REPORT_VALID=1 and REPORT_READY=1 at the same edge (accept and reload together; VALID stays 1).
  - If REPORT_VALID=1, REPORT_READY=0 and a new report arrives: keep the old data, drop the new one, set PERSO=1.
  - On acceptance with no new report, REPORT_VALID=0 from the next cycle.
  - REPORT_DATA holds stable while REPORT_VALID=1 and the record is not accepted.
- PERSO is cleared only by rst.

## Timing
- Reset values: STATO=00, REPORT_VALID=0, PERSO=0, and every counter and REPORT_DATA = 0.
- MANCHE/PARTITA/INIZIA sampled at edge k are reflected on all outputs immediately after edge k (1-cycle latency, all outputs registered, no combinational path from input to output).
- Handshake:
  - A transfer occurs at an edge where REPORT_VALID=1 and REPORT_READY=1.
  - REPORT_READY may toggle freely.
  - REPORT_VALID never depends combinationally on REPORT_READY.
- One match end per cycle at most; the throughput of one report per cycle is sustained when REPORT_READY is held at 1.
- rst=1 mid-match (including with INIZIA=1) returns to reset values at that edge. Session counters are also cleared.

## Test plan
- rst; INIZIA=1,MANCHE=01; then MANCHE=01, 10, then MANCHE=01 with PARTITA=01, REPORT_READY=0 -> VITTORIE_1=3, VITTORIE_2=1, MANCHE_GIOCATE=4, STATO=10, PARTITE_1=1, REPORT_VALID=1, REPORT_DATA={01,3,1,4}.
- In IDLE, drive MANCHE=01/PARTITA=10 for 3 cycles, then INIZIA=1 with MANCHE=00 -> counters stay 0 throughout, STATO=01 after the INIZIA edge, MANCHE_GIOCATE=0.
- Two matches end (P1, then draw) with REPORT_READY=0 -> PERSO=1, REPORT_DATA still first record, PARTITE_1=1, PARTITE_PARI=1. Then raise READY for one cycle -> REPORT_VALID=0 next cycle, PERSO stays 1.
- REPORT_READY=1 at the same edge a second match ends (PARTITA=10) -> REPORT_VALID stays 1, REPORT_DATA winner=10, PERSO=0.
- INIZIA then 20 cycles MANCHE=11, PARTITA=00 -> PAREGGI=15, MANCHE_GIOCATE=15 (saturated), STATO=01.
- Mid-match rst=1 together with INIZIA=1 and MANCHE=01 -> next cycle all outputs at reset values, STATO=00.

Source files
------------

// File: rtl/morra_tabellone.sv
// Scoreboard for the MorraCinese FSMD: per-match and per-session tallies, plus a
// single-entry report register drained over a valid/ready handshake.
module morra_tabellone #(
  parameter int CONT_W = 4,
  parameter int SESS_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    INIZIA,
  input  logic [1:0]              MANCHE,
  input  logic [1:0]              PARTITA,
  output logic [1:0]              STATO,
  output logic [CONT_W-1:0]       VITTORIE_1,
  output logic [CONT_W-1:0]       VITTORIE_2,
  output logic [CONT_W-1:0]       PAREGGI,
  output logic [CONT_W-1:0]       MANCHE_GIOCATE,
  output logic [SESS_W-1:0]       PARTITE_1,
  output logic [SESS_W-1:0]       PARTITE_2,
  output logic [SESS_W-1:0]       PARTITE_PARI,
  output logic                    REPORT_VALID,
  input  logic                    REPORT_READY,
  output logic [2+3*CONT_W-1:0]   REPORT_DATA,
  output logic                    PERSO
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GIOCO = 2'b01,
    S_FINE  = 2'b10
  } stato_t;

  stato_t                  r_stato;
  logic [CONT_W-1:0]       r_v1, r_v2, r_par, r_gioc;
  logic [SESS_W-1:0]       r_p1, r_p2, r_pp;
  logic                    r_valid, r_perso;
  logic [2+3*CONT_W-1:0]   r_data;

  logic                    w_active, w_end;
  logic [CONT_W-1:0]       w_v1, w_v2, w_par, w_gioc;
  logic [2+3*CONT_W-1:0]   w_report;

  function automatic logic [CONT_W-1:0] inc_cont(input logic [CONT_W-1:0] v);
    return (&v) ? v : v + CONT_W'(1);
  endfunction

  function automatic logic [SESS_W-1:0] inc_sess(input logic [SESS_W-1:0] v);
    return (&v) ? v : v + SESS_W'(1);
  endfunction

  // Next match counters: a start clears them first, then this cycle's round applies.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_active = INIZIA || (r_stato == S_GIOCO);
    w_end    = w_active && (PARTITA != 2'b00);
    w_v1     = INIZIA ? '0 : r_v1;
    w_v2     = INIZIA ? '0 : r_v2;
    w_par    = INIZIA ? '0 : r_par;
    w_gioc   = INIZIA ? '0 : r_gioc;
    if (w_active) begin
      case (MANCHE)
        2'b01:   w_v1  = inc_cont(w_v1);
        2'b10:   w_v2  = inc_cont(w_v2);
        2'b11:   w_par = inc_cont(w_par);
        default: ;
      endcase
      if (MANCHE != 2'b00) w_gioc = inc_cont(w_gioc);
    end
    w_report = {PARTITA, w_v1, w_v2, w_gioc};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stato <= S_IDLE;
      r_v1    <= '0;
      r_v2    <= '0;
      r_par   <= '0;
      r_gioc  <= '0;
      r_p1    <= '0;
      r_p2    <= '0;
      r_pp    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_perso <= 1'b0;
    end else begin
      r_v1   <= w_v1;
      r_v2   <= w_v2;
      r_par  <= w_par;
      r_gioc <= w_gioc;

      if (w_end)         r_stato <= S_FINE;
      else if (w_active) r_stato <= S_GIOCO;

      if (w_end) begin
        case (PARTITA)
          2'b01:   r_p1 <= inc_sess(r_p1);
          2'b10:   r_p2 <= inc_sess(r_p2);
          default: r_pp <= inc_sess(r_pp);
        endcase
        // A pending unaccepted record wins; the newcomer is dropped and flagged.
        if (!r_valid || REPORT_READY) begin
          r_valid <= 1'b1;
          r_data  <= w_report;
        end else begin
          r_perso <= 1'b1;
        end
      end else if (r_valid && REPORT_READY) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign STATO          = r_stato;
  assign VITTORIE_1     = r_v1;
  assign VITTORIE_2     = r_v2;
  assign PAREGGI        = r_par;
  assign MANCHE_GIOCATE = r_gioc;
  assign PARTITE_1      = r_p1;
  assign PARTITE_2      = r_p2;
  assign PARTITE_PARI   = r_pp;
  assign REPORT_VALID   = r_valid;
  assign REPORT_DATA    = r_data;
  assign PERSO          = r_perso;

endmodule

// File: tb/tb_morra_tabellone.sv
// Self-checking bench for morra_tabellone: directed scenarios plus a randomized
// run against a behavioural scoreboard model.
module tb_morra_tabellone;

  logic        clk;
  logic        rst;
  logic        INIZIA;
  logic [1:0]  MANCHE;
  logic [1:0]  PARTITA;
  logic [1:0]  STATO;
  logic [3:0]  VITTORIE_1, VITTORIE_2, PAREGGI, MANCHE_GIOCATE;
  logic [7:0]  PARTITE_1, PARTITE_2, PARTITE_PARI;
  logic        REPORT_VALID;
  logic        REPORT_READY;
  logic [13:0] REPORT_DATA;
  logic        PERSO;

  int n_pass;
  int n_total;

  morra_tabellone #(.CONT_W(4), .SESS_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .INIZIA        (INIZIA),
    .MANCHE        (MANCHE),
    .PARTITA       (PARTITA),
    .STATO         (STATO),
    .VITTORIE_1    (VITTORIE_1),
    .VITTORIE_2    (VITTORIE_2),
    .PAREGGI       (PAREGGI),
    .MANCHE_GIOCATE(MANCHE_GIOCATE),
    .PARTITE_1     (PARTITE_1),
    .PARTITE_2     (PARTITE_2),
    .PARTITE_PARI  (PARTITE_PARI),
    .REPORT_VALID  (REPORT_VALID),
    .REPORT_READY  (REPORT_READY),
    .REPORT_DATA   (REPORT_DATA),
    .PERSO         (PERSO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic i, input logic [1:0] m,
                      input logic [1:0] p, input logic y);
    rst = r; INIZIA = i; MANCHE = m; PARTITA = p; REPORT_READY = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 2'b00, 2'b00, 0);
    n_total++;
    if ({STATO, REPORT_VALID, PERSO} !== 4'b0000)
      $display("FAIL reset_ctrl got %b want 0000", {STATO, REPORT_VALID, PERSO});
    else n_pass++;
    n_total++;
    if ({VITTORIE_1, VITTORIE_2, PAREGGI, MANCHE_GIOCATE, PARTITE_1, PARTITE_2, PARTITE_PARI} !== 40'd0)
      $display("FAIL reset_counters got %h want 0",
               {VITTORIE_1, VITTORIE_2, PAREGGI, MANCHE_GIOCATE, PARTITE_1, PARTITE_2, PARTITE_PARI});
    else n_pass++;
    n_total++;
    if (REPORT_DATA !== 14'd0) $display("FAIL reset_data got %h want 0", REPORT_DATA);
    else n_pass++;
  endtask

  task automatic test_basic_match;
    step(1, 0, 2'b00, 2'b00, 0);
    step(0, 1, 2'b01, 2'b00, 0);
    n_total++;
    if (STATO !== 2'b01 || VITTORIE_1 !== 4'd1) $display("FAIL basic_first got stato=%b v1=%0d want 01/1", STATO, VITTORIE_1);
    else n_pass++;
    step(0, 0, 2'b01, 2'b00, 0);
    step(0, 0, 2'b10, 2'b00, 0);
    step(0, 0, 2'b01, 2'b01, 0);
    n_total++;
    if ({VITTORIE_1, VITTORIE_2, MANCHE_GIOCATE} !== {4'd3, 4'd1, 4'd4})
      $display("FAIL basic_counts got v1=%0d v2=%0d g=%0d want 3 1 4", VITTORIE_1, VITTORIE_2, MANCHE_GIOCATE);
    else n_pass++;
    n_total++;
    if (STATO !== 2'b10 || PARTITE_1 !== 8'd1 || REPORT_VALID !== 1'b1)
      $display("FAIL basic_end got stato=%b p1=%0d valid=%b want 10 1 1", STATO, PARTITE_1, REPORT_VALID);
    else n_pass++;
    n_total++;
    if (REPORT_DATA !== {2'b01, 4'd3, 4'd1, 4'd4})
      $display("FAIL basic_data got %h want %h", REPORT_DATA, {2'b01, 4'd3, 4'd1, 4'd4});
    else n_pass++;
  endtask

  task automatic test_idle_ignore;
    step(1, 0, 2'b00, 2'b00, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 2'b01, 2'b10, 0);
      n_total++;
      if ({STATO, VITTORIE_1, MANCHE_GIOCATE, PARTITE_2, REPORT_VALID} !== 19'd0)
        $display("FAIL idle_ignore got stato=%b v1=%0d g=%0d p2=%0d valid=%b want all 0",
                 STATO, VITTORIE_1, MANCHE_GIOCATE, PARTITE_2, REPORT_VALID);
      else n_pass++;
    end
    step(0, 1, 2'b00, 2'b00, 0);
    n_total++;
    if (STATO !== 2'b01 || MANCHE_GIOCATE !== 4'd0)
      $display("FAIL idle_start got stato=%b g=%0d want 01 0", STATO, MANCHE_GIOCATE);
    else n_pass++;
  endtask

  task automatic test_drop;
    step(1, 0, 2'b00, 2'b00, 0);
    step(0, 1, 2'b01, 2'b01, 0);
    step(0, 1, 2'b11, 2'b11, 0);
    n_total++;
    if (PERSO !== 1'b1 || REPORT_VALID !== 1'b1)
      $display("FAIL drop_flag got perso=%b valid=%b want 1 1", PERSO, REPORT_VALID);
    else n_pass++;
    n_total++;
    if (REPORT_DATA !== {2'b01, 4'd1, 4'd0, 4'd1})
      $display("FAIL drop_data got %h want %h", REPORT_DATA, {2'b01, 4'd1, 4'd0, 4'd1});
    else n_pass++;
    n_total++;
    if (PARTITE_1 !== 8'd1 || PARTITE_PARI !== 8'd1 || PAREGGI !== 4'd1)
      $display("FAIL drop_session got p1=%0d pp=%0d par=%0d want 1 1 1", PARTITE_1, PARTITE_PARI, PAREGGI);
    else n_pass++;
    step(0, 0, 2'b00, 2'b00, 1);
    step(0, 0, 2'b00, 2'b00, 0);
    n_total++;
    if (REPORT_VALID !== 1'b0 || PERSO !== 1'b1)
      $display("FAIL drop_drain got valid=%b perso=%b want 0 1", REPORT_VALID, PERSO);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    step(1, 0, 2'b00, 2'b00, 0);
    step(0, 1, 2'b01, 2'b01, 0);
    step(0, 1, 2'b10, 2'b10, 1);
    n_total++;
    if (REPORT_VALID !== 1'b1 || PERSO !== 1'b0)
      $display("FAIL b2b_flags got valid=%b perso=%b want 1 0", REPORT_VALID, PERSO);
    else n_pass++;
    n_total++;
    if (REPORT_DATA !== {2'b10, 4'd0, 4'd1, 4'd1})
      $display("FAIL b2b_data got %h want %h", REPORT_DATA, {2'b10, 4'd0, 4'd1, 4'd1});
    else n_pass++;
  endtask

  task automatic test_saturation;
    step(1, 0, 2'b00, 2'b00, 0);
    step(0, 1, 2'b11, 2'b00, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 2'b11, 2'b00, 0);
    n_total++;
    if (PAREGGI !== 4'd15 || MANCHE_GIOCATE !== 4'd15 || STATO !== 2'b01)
      $display("FAIL sat got par=%0d g=%0d stato=%b want 15 15 01", PAREGGI, MANCHE_GIOCATE, STATO);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    step(1, 0, 2'b00, 2'b00, 0);
    step(0, 1, 2'b01, 2'b01, 0);
    step(0, 1, 2'b01, 2'b00, 0);
    step(1, 1, 2'b01, 2'b00, 0);
    n_total++;
    if ({STATO, VITTORIE_1, VITTORIE_2, PAREGGI, MANCHE_GIOCATE, PARTITE_1, PARTITE_2, PARTITE_PARI,
         REPORT_VALID, REPORT_DATA, PERSO} !== 58'd0)
      $display("FAIL reset_mid got stato=%b v1=%0d g=%0d p1=%0d valid=%b data=%h want all 0",
               STATO, VITTORIE_1, MANCHE_GIOCATE, PARTITE_1, REPORT_VALID, REPORT_DATA);
    else n_pass++;
  endtask

  task automatic test_random;
    int mst, mv1, mv2, mpa, mg, mp1, mp2, mpp;
    logic mvalid, mperso;
    logic [13:0] mdata;
    logic r, i, y;
    logic [1:0] m, p;
    logic [57:0] act, exp_v;
    bit active;
    step(1, 0, 2'b00, 2'b00, 0);
    mst = 0; mv1 = 0; mv2 = 0; mpa = 0; mg = 0; mp1 = 0; mp2 = 0; mpp = 0;
    mvalid = 0; mperso = 0; mdata = '0;
    for (int c = 0; c < 800; c++) begin
      r = ($urandom_range(0, 59) == 0);
      i = ($urandom_range(0, 6) == 0);
      m = 2'($urandom_range(0, 3));
      p = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      y = 1'($urandom_range(0, 1));
      step(r, i, m, p, y);
      if (r) begin
        mst = 0; mv1 = 0; mv2 = 0; mpa = 0; mg = 0; mp1 = 0; mp2 = 0; mpp = 0;
        mvalid = 0; mperso = 0; mdata = '0;
      end else begin
        active = i || (mst == 1);
        if (i) begin mv1 = 0; mv2 = 0; mpa = 0; mg = 0; end
        if (active && m != 2'b00) begin
          if (m == 2'b01) mv1 = (mv1 < 15) ? mv1 + 1 : 15;
          if (m == 2'b10) mv2 = (mv2 < 15) ? mv2 + 1 : 15;
          if (m == 2'b11) mpa = (mpa < 15) ? mpa + 1 : 15;
          mg = (mg < 15) ? mg + 1 : 15;
        end
        if (active && p != 2'b00) begin
          mst = 2;
          if (p == 2'b01) mp1 = (mp1 < 255) ? mp1 + 1 : 255;
          if (p == 2'b10) mp2 = (mp2 < 255) ? mp2 + 1 : 255;
          if (p == 2'b11) mpp = (mpp < 255) ? mpp + 1 : 255;
          if (!mvalid || y) begin
            mvalid = 1;
            mdata = {p, 4'(mv1), 4'(mv2), 4'(mg)};
          end else mperso = 1;
        end else begin
          if (active) mst = 1;
          if (mvalid && y) mvalid = 0;
        end
      end
      act = {STATO, VITTORIE_1, VITTORIE_2, PAREGGI, MANCHE_GIOCATE, PARTITE_1, PARTITE_2,
             PARTITE_PARI, REPORT_VALID, REPORT_DATA, PERSO};
      exp_v = {2'(mst), 4'(mv1), 4'(mv2), 4'(mpa), 4'(mg), 8'(mp1), 8'(mp2), 8'(mpp),
               mvalid, mdata, mperso};
      n_total++;
      if (act !== exp_v) $display("FAIL random cycle %0d got %h want %h", c, act, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1; INIZIA = 1'b0; MANCHE = 2'b00; PARTITA = 2'b00; REPORT_READY = 1'b0;
    test_reset;
    test_basic_match;
    test_idle_ignore;
    test_drop;
    test_back_to_back;
    test_saturation;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
